// File: rtl/counter_pkg.sv
// counter_pkg: direction constants and load clamping shared by counter blocks.
package counter_pkg;
   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DOWN = 1'b0;
   function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] modulus);
      return (val >= modulus) ? modulus - 32'd1 : val;
   endfunction
endpackage

// File: rtl/mod_counter_next.sv
// mod_counter_next: combinational next count and wrap flag for one counter stage.
// MOD_COUNTER_SAT_EN selects saturation at the range limits instead of wrapping.
module mod_counter_next import counter_pkg::*; #(
   parameter int WIDTH = 4,
   parameter int MODULUS = 10
) (
   input  logic [WIDTH-1:0] count,
   input  logic             up,
   input  logic             step,
   output logic [WIDTH-1:0] nxt,
   output logic             wrap
);
   // One extra bit keeps MODULUS == 2**WIDTH from aliasing to zero.
   localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
   logic [WIDTH:0] c, n;
   logic at_limit;
   always_comb begin
      c = {1'b0, count};
      at_limit = (up == DIR_UP) ? c == LAST : c == '0;
`ifdef MOD_COUNTER_SAT_EN
      n = at_limit ? c : (up == DIR_UP) ? c + ONE : c - ONE;
      wrap = 1'b0;
`else
      n = (up == DIR_UP) ? (at_limit ? '0 : c + ONE) : (at_limit ? LAST : c - ONE);
      wrap = step & at_limit;
`endif
      nxt = step ? n[WIDTH-1:0] : count;
   end
endmodule

// File: rtl/mod_counter.sv
// mod_counter: modulo-N up/down counter stage with load, cascade carry and wrap pulse.
// MOD_COUNTER_SAT_EN (in mod_counter_next) switches to saturating behaviour.
module mod_counter import counter_pkg::*; #(
   parameter int WIDTH = 4,
   parameter int MODULUS = 10,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             cin,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             cout,
   output logic             wrap
);
   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
   logic [WIDTH-1:0] nxt;
   logic nxt_wrap;
   mod_counter_next #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_next (
      .count(count),
      .up(up),
      .step(en & cin),
      .nxt(nxt),
      .wrap(nxt_wrap)
   );
   assign tc = (up == DIR_UP) ? count == LAST : count == '0;
   assign cout = en & cin & tc;
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= WIDTH'(RESET_VAL);
         wrap <= 1'b0;
      end else if (load) begin
         count <= WIDTH'(clamp_load(32'(load_val), 32'(MODULUS)));
         wrap <= 1'b0;
      end else begin
         count <= nxt;
         wrap <= nxt_wrap;
      end
   end
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: vector table, hand sequences and randomized model check of mod_counter.
module tb_mod_counter;
`ifdef MOD_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 0, en = 0, up = 0, cin = 0, load = 0;
   logic [3:0] load_val = 0;
   logic [3:0] count;
   logic tc, cout, wrap;
   mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .cin(cin), .load(load), .load_val(load_val),
      .count(count), .tc(tc), .cout(cout), .wrap(wrap)
   );

   logic en_c = 0;
   logic [3:0] u_count, t_count;
   logic u_tc, u_cout, u_wrap, t_tc, t_cout, t_wrap;
   mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) units (
      .clk(clk), .rst(rst), .en(en_c), .up(1'b1), .cin(1'b1), .load(1'b0), .load_val(4'd0),
      .count(u_count), .tc(u_tc), .cout(u_cout), .wrap(u_wrap)
   );
   mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) tens (
      .clk(clk), .rst(rst), .en(en_c), .up(1'b1), .cin(u_cout), .load(1'b0), .load_val(4'd0),
      .count(t_count), .tc(t_tc), .cout(t_cout), .wrap(t_wrap)
   );

   logic en16 = 0, up16 = 0, load16 = 0;
   logic [3:0] lv16 = 0;
   logic [3:0] c16;
   logic tc16, cout16, wrap16;
   mod_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(5)) full (
      .clk(clk), .rst(rst), .en(en16), .up(up16), .cin(1'b1), .load(load16), .load_val(lv16),
      .count(c16), .tc(tc16), .cout(cout16), .wrap(wrap16)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference step: modular arithmetic on plain integers.
   function automatic void mstep(input int c, input bit dir_up, input bit st, input int m,
                                 output int n, output bit w);
      n = c;
      w = 0;
      if (st) begin
         if (dir_up) begin
            if (c == m - 1) begin n = SAT ? c : 0; w = !SAT; end
            else n = c + 1;
         end else begin
            if (c == 0) begin n = SAT ? c : m - 1; w = !SAT; end
            else n = c - 1;
         end
      end
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit rst, load, en, cin, up;
      logic [3:0] lv;
      int cnt;
      bit wr, tc, co;
   } vec_t;
   vec_t tbl[13];

   int m, n, mt, nt;
   bit w, wt;

   initial begin
      tbl[0]  = '{1, 0, 1, 1, 1, 4'd0,  0, 0, 0, 0};
      tbl[1]  = '{1, 0, 1, 1, 1, 4'd0,  0, 0, 0, 0};
      tbl[2]  = '{0, 1, 1, 1, 1, 4'd7,  7, 0, 0, 0};
      tbl[3]  = '{0, 1, 1, 1, 1, 4'd13, 9, 0, 1, 1};
      tbl[4]  = '{0, 0, 1, 1, 1, 4'd0,  SAT ? 9 : 0, !SAT, SAT, SAT};
      tbl[5]  = '{0, 0, 1, 0, 1, 4'd0,  SAT ? 9 : 0, 0, SAT, 0};
      tbl[6]  = '{0, 0, 1, 1, 0, 4'd0,  SAT ? 8 : 9, !SAT, 0, 0};
      tbl[7]  = '{0, 0, 1, 1, 0, 4'd0,  SAT ? 7 : 8, 0, 0, 0};
      tbl[8]  = '{0, 1, 1, 1, 0, 4'd0,  0, 0, 1, 1};
      tbl[9]  = '{1, 1, 1, 1, 1, 4'd5,  0, 0, 0, 0};
      tbl[10] = '{0, 0, 0, 1, 0, 4'd0,  0, 0, 1, 0};
      tbl[11] = '{0, 1, 1, 1, 1, 4'd9,  9, 0, 1, 1};
      tbl[12] = '{0, 1, 0, 1, 0, 4'd15, 9, 0, 0, 0};
      #2;
      foreach (tbl[i]) begin
         rst = tbl[i].rst; load = tbl[i].load; en = tbl[i].en;
         cin = tbl[i].cin; up = tbl[i].up; load_val = tbl[i].lv;
         tick();
         chk($sformatf("vec%0d count", i), 32'(count), tbl[i].cnt);
         chk($sformatf("vec%0d wrap", i), 32'(wrap), 32'(tbl[i].wr));
         chk($sformatf("vec%0d tc", i), 32'(tc), 32'(tbl[i].tc));
         chk($sformatf("vec%0d cout", i), 32'(cout), 32'(tbl[i].co));
      end

      // Reset then free-run up through one full cycle.
      rst = 1; load = 0; en = 1; cin = 1; up = 1;
      tick(); tick();
      chk("reset count", 32'(count), 0);
      chk("reset wrap", 32'(wrap), 0);
      chk("reset tc", 32'(tc), 0);
      chk("full reset value", 32'(c16), 5);
      rst = 0;
      m = 0;
      for (int i = 0; i < 10; i++) begin
         mstep(m, 1, 1, 10, n, w);
         m = n;
         tick();
         chk("run count", 32'(count), m);
         chk("run wrap", 32'(wrap), 32'(w));
         chk("run tc", 32'(tc), 32'(m == 9));
      end

      // Saturation / wrap from 8 upward.
      load = 1; load_val = 8; tick(); load = 0;
      m = 8;
      for (int i = 0; i < 5; i++) begin
         mstep(m, 1, 1, 10, n, w);
         m = n;
         tick();
         chk("from8 count", 32'(count), m);
         chk("from8 wrap", 32'(wrap), 32'(w));
         chk("from8 cout", 32'(cout), 32'(m == 9));
      end

      // Full-range modulus 16 at both ends.
      load16 = 1; lv16 = 15; up16 = 1; en16 = 1; tick(); load16 = 0;
      chk("m16 load15", 32'(c16), 15);
      chk("m16 tc at 15", 32'(tc16), 1);
      tick();
      chk("m16 up wrap count", 32'(c16), SAT ? 15 : 0);
      chk("m16 up wrap pulse", 32'(wrap16), 32'(!SAT));
      up16 = 0;
      load16 = 1; lv16 = 0; tick(); load16 = 0;
      chk("m16 down tc", 32'(cout16), 1);
      tick();
      chk("m16 down wrap count", 32'(c16), SAT ? 0 : 15);
      chk("m16 down wrap pulse", 32'(wrap16), 32'(!SAT));
      en16 = 0;

      // Two-stage cascade over 100 enabled cycles.
      rst = 1; en = 0; en_c = 1; tick(); rst = 0;
      m = 0; mt = 0;
      for (int i = 1; i <= 100; i++) begin
         #1;
         chk("casc cout", 32'(u_cout), 32'(m == 9));
         mstep(mt, 1, m == 9, 10, nt, wt);
         mstep(m, 1, 1, 10, n, w);
         m = n; mt = nt;
         @(posedge clk); #1;
         chk("casc units", 32'(u_count), m);
         chk("casc tens", 32'(t_count), mt);
         chk("casc units wrap", 32'(u_wrap), 32'(w));
         chk("casc tens wrap", 32'(t_wrap), 32'(wt));
      end
      if (!SAT) begin
         chk("casc final tens", 32'(t_count), 0);
         chk("casc final tens wrap", 32'(t_wrap), 1);
      end
      en_c = 0;

      // Randomized run against the reference model.
      rst = 1; tick(); rst = 0;
      m = 0;
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 40) == 0);
         load = ($urandom_range(0, 7) == 0);
         en = ($urandom_range(0, 3) != 0);
         cin = ($urandom_range(0, 3) != 0);
         up = 1'($urandom);
         load_val = 4'($urandom);
         #1;
         chk("rnd tc", 32'(tc), 32'(up ? m == 9 : m == 0));
         chk("rnd cout", 32'(cout), 32'(en && cin && (up ? m == 9 : m == 0)));
         if (rst) begin n = 0; w = 0; end
         else if (load) begin n = (load_val > 9) ? 9 : int'(load_val); w = 0; end
         else mstep(m, up, en && cin, 10, n, w);
         m = n;
         @(posedge clk); #1;
         chk("rnd count", 32'(count), m);
         chk("rnd wrap", 32'(wrap), 32'(w));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
